// File: rtl/excess3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// excess3_pkg : shared constants and types for the Excess-3 decoder slice
// Revision    : 1.0
// ---------------------------------------------------------------------------
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET = 4'd3;
  localparam logic [3:0] E3_MIN    = 4'h3;
  localparam logic [3:0] E3_MAX    = 4'hC;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage
`default_nettype wire

// File: rtl/excess3_digit_dec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// excess3_digit_dec : combinational Excess-3 to BCD digit decode
// Revision          : 1.0
// ---------------------------------------------------------------------------
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] e,
  output logic [3:0] bcd,
  output logic       invalid
);

  assign invalid = (e < E3_MIN) || (e > E3_MAX);
  // Invalid codes store a zero digit so the packed word stays legal BCD.
  assign bcd     = invalid ? 4'h0 : (e - E3_OFFSET);

endmodule
`default_nettype wire

// File: rtl/excess3_to_bcd_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// excess3_to_bcd_stream : serial Excess-3 digits in (LSD first), packed BCD out
// Revision              : 1.0
// ---------------------------------------------------------------------------
module excess3_to_bcd_stream
  import excess3_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_digit,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_bcd,
  output logic [CW-1:0]        out_ndigits,
  output logic                 out_err
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NDIGITS - 1);

  state_t         state;
  logic [CW-1:0]  idx;
  bcd_digit_t     dec_bcd;
  logic           dec_invalid;
  logic           accept;

  excess3_digit_dec u_dec (
    .e       (in_digit),
    .bcd     (dec_bcd),
    .invalid (dec_invalid)
  );

  // Ready depends on state alone, keeping handshakes free of comb paths.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      idx         <= '0;
      out_bcd     <= '0;
      out_ndigits <= '0;
      out_err     <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            out_bcd[4*idx +: 4] <= dec_bcd;
            out_err             <= out_err | dec_invalid;
            if (in_last || (idx == LAST_IDX)) begin
              state       <= HOLD;
              out_valid   <= 1'b1;
              out_ndigits <= idx + 1'b1;
              idx         <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= ACCUM;
            out_valid   <= 1'b0;
            out_bcd     <= '0;
            out_ndigits <= '0;
            out_err     <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_excess3_to_bcd_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_excess3_to_bcd_stream : randomized self-checking bench, decimal model
// Revision                 : 1.0
// ---------------------------------------------------------------------------
module tb_excess3_to_bcd_stream;

  localparam int NDIGITS = 4;
  localparam int CW      = $clog2(NDIGITS + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [3:0]           in_digit = 4'h0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [4*NDIGITS-1:0] out_bcd;
  logic [CW-1:0]        out_ndigits;
  logic                 out_err;

  int tests_run    = 0;
  int tests_failed = 0;

  excess3_to_bcd_stream #(.NDIGITS(NDIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_digit    (in_digit),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_ndigits (out_ndigits),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  // Reference: decimal value of the received digits, re-expanded to BCD.
  function automatic void model(input logic [3:0] codes[NDIGITS], input int n,
                                output logic [4*NDIGITS-1:0] bcd,
                                output logic [CW-1:0] nd, output logic err);
    int val = 0;
    int p = 1;
    err = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (codes[i] >= 3 && codes[i] <= 12) val += (int'(codes[i]) - 3) * p;
      else err = 1'b1;
      p *= 10;
    end
    bcd = '0;
    p = 1;
    for (int i = 0; i < NDIGITS; i++) begin
      bcd[4*i +: 4] = 4'((val / p) % 10);
      p *= 10;
    end
    nd = CW'(n);
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_digit(input logic [3:0] c, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_digit = c;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for a word, captures it and consumes it with a one-cycle out_ready.
  task automatic get_word(output logic [4*NDIGITS-1:0] bcd, output logic [CW-1:0] nd,
                          output logic err, output bit ok);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok  = out_valid;
    bcd = out_bcd;
    nd  = out_ndigits;
    err = out_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({in_ready, out_valid, out_bcd, out_ndigits, out_err} !== {1'b1, 1'b0, 16'h0, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: rdy=%0b vld=%0b bcd=%h nd=%0d err=%0b required rdy=1 vld=0 bcd=0000 nd=0 err=0",
               in_ready, out_valid, out_bcd, out_ndigits, out_err);
    end
  endtask

  task automatic test_full_word();
    logic [4*NDIGITS-1:0] b; logic [CW-1:0] nd; logic e; bit ok;
    send_digit(4'h7, 1'b0); send_digit(4'h5, 1'b0);
    send_digit(4'hC, 1'b0); send_digit(4'h3, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_latency: vld=%0b rdy=%0b required vld=1 rdy=0", out_valid, in_ready);
    end
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0924, 3'd4, 1'b0}) begin
      tests_failed++;
      $display("FAIL full_word: ok=%0b bcd=%h nd=%0d err=%0b required 0924 4 0", ok, b, nd, e);
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_consume: vld=%0b rdy=%0b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_short();
    logic [4*NDIGITS-1:0] b; logic [CW-1:0] nd; logic e; bit ok;
    send_digit(4'h4, 1'b1);
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0001, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL short1: ok=%0b bcd=%h nd=%0d err=%0b required 0001 1 0", ok, b, nd, e);
    end
    send_digit(4'h8, 1'b0); send_digit(4'h6, 1'b1);
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0035, 3'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL short2: ok=%0b bcd=%h nd=%0d err=%0b required 0035 2 0", ok, b, nd, e);
    end
  endtask

  task automatic test_invalid();
    logic [4*NDIGITS-1:0] b; logic [CW-1:0] nd; logic e; bit ok;
    send_digit(4'h7, 1'b0); send_digit(4'hF, 1'b1);
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0004, 3'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL invalid: ok=%0b bcd=%h nd=%0d err=%0b required 0004 2 1", ok, b, nd, e);
    end
    send_digit(4'h3, 1'b1);
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0000, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL err_clear: ok=%0b bcd=%h nd=%0d err=%0b required 0000 1 0", ok, b, nd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [4*NDIGITS-1:0] b; logic [CW-1:0] nd; logic e; bit ok;
    send_digit(4'h7, 1'b0); send_digit(4'h5, 1'b0);
    send_digit(4'hC, 1'b0); send_digit(4'h3, 1'b0);
    in_valid = 1'b1; in_digit = 4'h9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({in_ready, out_valid, out_bcd, out_ndigits, out_err} !== {1'b0, 1'b1, 16'h0924, 3'd4, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: rdy=%0b vld=%0b bcd=%h nd=%0d err=%0b required 0 1 0924 4 0",
                 i, in_ready, out_valid, out_bcd, out_ndigits, out_err);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: rdy=%0b vld=%0b required rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0006, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_next: ok=%0b bcd=%h nd=%0d err=%0b required 0006 1 0", ok, b, nd, e);
    end
  endtask

  task automatic test_reset_midword();
    logic [4*NDIGITS-1:0] b; logic [CW-1:0] nd; logic e; bit ok;
    send_digit(4'h7, 1'b0); send_digit(4'h5, 1'b0);
    #2 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({out_valid, out_bcd, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_mid: vld=%0b bcd=%h rdy=%0b required 0 0000 1", out_valid, out_bcd, in_ready);
    end
    send_digit(4'hB, 1'b1);
    get_word(b, nd, e, ok);
    tests_run++;
    if (!ok || {b, nd, e} !== {16'h0008, 3'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_next: ok=%0b bcd=%h nd=%0d err=%0b required 0008 1 0", ok, b, nd, e);
    end
  endtask

  task automatic test_sweep();
    logic [4*NDIGITS-1:0] b, eb; logic [CW-1:0] nd, end_; logic e, ee; bit ok;
    logic [3:0] codes[NDIGITS];
    for (int c = 0; c < 16; c++) begin
      codes[0] = 4'(c);
      model(codes, 1, eb, end_, ee);
      send_digit(4'(c), 1'b1);
      get_word(b, nd, e, ok);
      tests_run++;
      if (!ok || {b, nd, e} !== {eb, end_, ee}) begin
        tests_failed++;
        $display("FAIL sweep[%h]: ok=%0b bcd=%h nd=%0d err=%0b required %h %0d %0b",
                 c, ok, b, nd, e, eb, end_, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4*NDIGITS-1:0] b, eb; logic [CW-1:0] nd, end_; logic e, ee; bit ok;
    logic [3:0] codes[NDIGITS];
    int n;
    for (int w = 0; w < 40; w++) begin
      n = $urandom_range(1, NDIGITS);
      for (int i = 0; i < n; i++)
        codes[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(3, 12));
      model(codes, n, eb, end_, ee);
      for (int i = 0; i < n; i++)
        send_digit(codes[i], (i == n - 1) && (n < NDIGITS || $urandom_range(0, 1) == 1));
      get_word(b, nd, e, ok);
      tests_run++;
      if (!ok || {b, nd, e} !== {eb, end_, ee}) begin
        tests_failed++;
        $display("FAIL rand[%0d]: ok=%0b bcd=%h nd=%0d err=%0b required %h %0d %0b",
                 w, ok, b, nd, e, eb, end_, ee);
      end
    end
  endtask

  initial begin
    #20 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_short();
    test_invalid();
    test_backpressure();
    test_reset_midword();
    test_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/excess3_to_bcd_stream.md
Name: excess3_to_bcd_stream

Overview:
Serial Excess-3 to BCD decoder. It is the receive-side counterpart of the BCD to Excess-3 encoder.
- Accepts one Excess-3 digit per valid/ready handshake, least-significant digit first.
- Subtracts the offset of 3 from each digit and packs the results into an NDIGITS-wide BCD word.
- Flags invalid codes.
- Presents the finished word on a valid/ready output port backed by a one-entry holding register.
- Sits between the serial Excess-3 link and downstream BCD arithmetic/display logic.

Parameters:
NDIGITS, 4, number of BCD digits per output word (legal range 1..8).
CW, $clog2(NDIGITS+1), width of the digit-count output (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_valid  input  1  in_digit/in_last are valid.
in_ready  output  1  block can accept a digit this cycle.
in_digit  input  4  Excess-3 code for one decimal digit.
in_last  input  1  this digit is the final (most-significant) digit of the number.
out_valid  output  1  out_bcd/out_ndigits/out_err hold a completed word.
out_ready  input  1  downstream accepts the word.
out_bcd  output  4*NDIGITS  packed BCD; digit i occupies bits [4i+3:4i].
out_ndigits  output  CW  number of digits received for this word (1..NDIGITS).
out_err  output  1  at least one digit of this word was an invalid Excess-3 code.

Behaviour:
- Reset (async assert, sync release):
  - state=ACCUM, digit index=0, out_bcd=0, out_ndigits=0, out_err=0, out_valid=0.
  - in_ready=1 from the first cycle after release.
- Digit decode (combinational):
  - valid codes 4'h3..4'hC; bcd = e - 4'd3, 4-bit result.
  - codes 4'h0..4'h2 and 4'hD..4'hF are invalid: the stored digit is 4'h0 and the word error flag is set.
- Acceptance: a digit is accepted when in_valid && in_ready.
- FSM, 2 states:
  - ACCUM:
    - in_ready=1, out_valid=0.
    - On accept: write the decoded digit to slot idx; OR the invalid flag into the error register; idx<=idx+1.
    - If in_last=1 or idx==NDIGITS-1: go to HOLD, with out_ndigits=idx+1. idx resets to 0 on the transition.
  - HOLD:
    - in_ready=0, out_valid=1; all outputs held stable.
    - When out_ready=1: clear out_bcd, out_err and out_ndigits; go to ACCUM.
- Latency: out_valid rises on the cycle after the final digit is accepted.
- Throughput: at least one bubble cycle per word (in_ready=0 in the cycle the word is consumed). Peak rate is NDIGITS digits per NDIGITS+1 cycles.
- Short numbers: when in_last is asserted before slot NDIGITS-1, the unwritten upper digits read 4'h0.
- Full word without in_last: the word completes at slot NDIGITS-1. The next accepted digit starts a new word.
- in_last on slot NDIGITS-1: identical to completion without in_last.
- in_valid while in HOLD: ignored, not accepted. The upstream source must hold the digit until in_ready is high again.
- out_ready while in ACCUM: no effect.
- Reset mid-word or mid-HOLD:
  - any partial or held word is discarded; no out_valid pulse follows.
  - after reset release, the next accepted digit goes to slot 0.
- All outputs are driven from registers except in_ready, which is decoded from state only (no combinational path from out_ready or in_valid).

Decomposition:
- Shared package excess3_pkg:
  - E3_OFFSET=4'd3, E3_MIN=4'h3, E3_MAX=4'hC.
  - typedef of the state enum {ACCUM, HOLD}.
  - BCD digit typedef (4-bit).
- One natural sub-module, excess3_digit_dec: purely combinational; input 4-bit e; outputs 4-bit bcd and 1-bit invalid. Instantiated once on in_digit.

Test Plan:
1. NDIGITS=4; send 4'h7, 4'h5, 4'hC, 4'h3 (no in_last), out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_bcd=16'h0924, out_ndigits=4, out_err=0.
2. Short word: send 4'h4 with in_last=1 -> out_bcd=16'h0001, out_ndigits=1, out_err=0. Next word 4'h8, 4'h6, in_last -> out_bcd=16'h0035, out_ndigits=2.
3. Invalid code: send 4'h7, 4'hF, in_last -> out_bcd=16'h0004, out_ndigits=2, out_err=1. Next clean word 4'h3, last -> out_err=0.
4. Backpressure:
   - stimulus: complete word 16'h0924; hold out_ready=0 for 5 cycles while in_valid=1 with digit 4'h9 presented.
   - outputs: in_ready=0 and outputs stable for all 5 cycles.
   - after out_ready=1: word consumed and in_ready=1 on the following cycle.
   - 4'h9 is then accepted into slot 0 of the next word, decoding to 6.
5. Reset mid-word: accept 4'h7, 4'h5, pulse rst_n low asynchronously (not clock-aligned), release, then send 4'hB, in_last -> out_bcd=16'h0008, out_ndigits=1, no spurious out_valid before it.
6. Exhaustive decode sweep:
   - send each code 4'h0..4'hF as a 1-digit word.
   - codes 3..C -> out_bcd = code-3 with err=0.
   - codes 0..2 and D..F -> out_bcd=0 with err=1.
